// File: rtl/xmas_pkg.sv
// Shared xMAS primitive definitions: channel state encoding and common widths.
package xmas_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBlocked
    } chan_state_e;

    localparam int unsigned DefaultDataW = 8;
    localparam int unsigned StallCntW    = 8;

endpackage

// File: rtl/xmas_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at Max.
module xmas_sat_counter #(
    parameter int unsigned      Width = 8,
    parameter logic [Width-1:0] Max   = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != Max)) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/xmas_fair_sink.sv
// xMAS sink with oracle-driven but bounded-fair acceptance, plus channel
// persistence and in-order data checking.
module xmas_fair_sink
    import xmas_pkg::*;
#(
    parameter int unsigned DATA_W    = DefaultDataW,
    parameter int unsigned MAX_STALL = 4,
    parameter int unsigned CNT_W     = 16,
    parameter bit          CHECK_SEQ = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 oracle,
    input  logic                 i_irdy,
    input  logic [DATA_W-1:0]    i_data,
    output logic                 i_trdy,
    output logic [CNT_W-1:0]     pkt_count,
    output logic [StallCntW-1:0] stall_cnt,
    output logic                 err_persist,
    output logic                 err_order
);

    localparam logic [StallCntW-1:0] MaxStall = StallCntW'(MAX_STALL);

    chan_state_e       state_d, state_q;
    logic [DATA_W-1:0] held_d, held_q;
    logic [DATA_W-1:0] exp_d, exp_q;
    logic              err_persist_d, err_persist_q;
    logic              err_order_d, err_order_q;
    logic              xfer, blocked;

    // Independent of i_irdy so the sink never closes a combinational loop.
    assign i_trdy  = !reset && (oracle || (stall_cnt == MaxStall));
    assign xfer    = i_irdy && i_trdy;
    assign blocked = i_irdy && !i_trdy;

    always_comb begin
        state_d       = blocked ? StBlocked : StIdle;
        held_d        = held_q;
        exp_d         = exp_q;
        err_persist_d = err_persist_q;
        err_order_d   = err_order_q;

        if ((state_q == StIdle) && blocked) begin
            held_d = i_data;
        end
        if ((state_q == StBlocked) && (!i_irdy || (i_data != held_q))) begin
            err_persist_d = 1'b1;
        end
        // Resynchronise to the received value so each gap is flagged once.
        if (xfer) begin
            exp_d = i_data + DATA_W'(1);
            if (CHECK_SEQ && (i_data != exp_q)) begin
                err_order_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            held_q        <= '0;
            exp_q         <= '0;
            err_persist_q <= 1'b0;
            err_order_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            held_q        <= held_d;
            exp_q         <= exp_d;
            err_persist_q <= err_persist_d;
            err_order_q   <= err_order_d;
        end
    end

    // Any non-blocked cycle ends the current stall.
    xmas_sat_counter #(
        .Width (StallCntW),
        .Max   (MaxStall)
    ) u_stall_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (!blocked),
        .inc_i   (blocked),
        .count_o (stall_cnt)
    );

    xmas_sat_counter #(
        .Width (CNT_W),
        .Max   ({CNT_W{1'b1}})
    ) u_pkt_cnt (
        .clk_i   (clk),
        .rst_i   (reset),
        .clear_i (1'b0),
        .inc_i   (xfer),
        .count_o (pkt_count)
    );

    assign err_persist = err_persist_q;
    assign err_order   = err_order_q;

endmodule

// File: tb/tb_xmas_fair_sink.sv
// Directed bench for xmas_fair_sink; a CNT_W=4 twin shares the stimulus
// to exercise packet counter saturation.
module tb_xmas_fair_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic        oracle;
    logic        i_irdy;
    logic [7:0]  i_data;
    logic        i_trdy, i_trdy4;
    logic [15:0] pkt_count;
    logic [3:0]  pkt_count4;
    logic [7:0]  stall_cnt, stall_cnt4;
    logic        err_persist, err_order, err_persist4, err_order4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xmas_fair_sink #(
        .DATA_W    (8),
        .MAX_STALL (4),
        .CNT_W     (16),
        .CHECK_SEQ (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .oracle      (oracle),
        .i_irdy      (i_irdy),
        .i_data      (i_data),
        .i_trdy      (i_trdy),
        .pkt_count   (pkt_count),
        .stall_cnt   (stall_cnt),
        .err_persist (err_persist),
        .err_order   (err_order)
    );

    xmas_fair_sink #(
        .DATA_W    (8),
        .MAX_STALL (4),
        .CNT_W     (4),
        .CHECK_SEQ (1'b1)
    ) dut4 (
        .clk         (clk),
        .reset       (reset),
        .oracle      (oracle),
        .i_irdy      (i_irdy),
        .i_data      (i_data),
        .i_trdy      (i_trdy4),
        .pkt_count   (pkt_count4),
        .stall_cnt   (stall_cnt4),
        .err_persist (err_persist4),
        .err_order   (err_order4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        oracle = 1'b0;
        i_irdy = 1'b0;
        i_data = 8'h00;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        oracle = 1'b1;
        i_irdy = 1'b1;
        i_data = 8'h00;
        step();
        step();
        checks++;
        if (i_trdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_trdy: got %0b want 0", i_trdy);
        end
        checks++;
        if (pkt_count !== 16'd0 || pkt_count4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_pkt: got %0d/%0d want 0/0", pkt_count, pkt_count4);
        end
        checks++;
        if (stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d want 0", stall_cnt);
        end
        checks++;
        if (err_persist !== 1'b0 || err_order !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %0b%0b want 00", err_persist, err_order);
        end
    endtask

    task automatic test_oracle_accept();
        do_reset();
        oracle = 1'b1;
        i_irdy = 1'b1;
        for (int d = 0; d < 4; d++) begin
            i_data = 8'(d);
            #1;
            checks++;
            if (i_trdy !== 1'b1) begin
                errors++;
                $display("FAIL oracle_trdy: got %0b want 1 (beat %0d)", i_trdy, d);
            end
            step();
        end
        i_irdy = 1'b0;
        checks++;
        if (pkt_count !== 16'd4) begin
            errors++;
            $display("FAIL oracle_pkt: got %0d want 4", pkt_count);
        end
        checks++;
        if (err_persist !== 1'b0 || err_order !== 1'b0) begin
            errors++;
            $display("FAIL oracle_err: got %0b%0b want 00", err_persist, err_order);
        end
    endtask

    task automatic test_forced();
        do_reset();
        oracle = 1'b0;
        i_irdy = 1'b1;
        i_data = 8'h00;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (stall_cnt !== 8'(k)) begin
                errors++;
                $display("FAIL forced_stall: got %0d want %0d", stall_cnt, k);
            end
            checks++;
            if (i_trdy !== (k == 4)) begin
                errors++;
                $display("FAIL forced_trdy: got %0b want %0b (cycle %0d)", i_trdy, k == 4, k);
            end
            step();
        end
        i_irdy = 1'b0;
        checks++;
        if (stall_cnt !== 8'd0 || pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL forced_done: got stall %0d pkt %0d want 0 1", stall_cnt, pkt_count);
        end
        checks++;
        if (err_persist !== 1'b0 || err_order !== 1'b0) begin
            errors++;
            $display("FAIL forced_err: got %0b%0b want 00", err_persist, err_order);
        end
    endtask

    task automatic test_persist();
        do_reset();
        oracle = 1'b0;
        i_irdy = 1'b1;
        i_data = 8'h05;
        step();
        checks++;
        if (err_persist !== 1'b0) begin
            errors++;
            $display("FAIL persist_pre: got %0b want 0", err_persist);
        end
        i_data = 8'h06;
        step();
        checks++;
        if (err_persist !== 1'b1) begin
            errors++;
            $display("FAIL persist_change: got %0b want 1", err_persist);
        end
        i_irdy = 1'b0;
        step();
        step();
        step();
        checks++;
        if (err_persist !== 1'b1 || err_order !== 1'b0) begin
            errors++;
            $display("FAIL persist_sticky: got %0b%0b want 10", err_persist, err_order);
        end
        // Withdrawal of a blocked packet is also a violation.
        do_reset();
        i_irdy = 1'b1;
        i_data = 8'h07;
        step();
        i_irdy = 1'b0;
        step();
        checks++;
        if (err_persist !== 1'b1) begin
            errors++;
            $display("FAIL persist_withdraw: got %0b want 1", err_persist);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        i_irdy = 1'b1;
        i_data = 8'h00;
        step();
        i_data = 8'h09;
        oracle = 1'b1;
        step();
        i_irdy = 1'b0;
        checks++;
        if (err_persist !== 1'b1 || err_order !== 1'b1 || pkt_count !== 16'd1) begin
            errors++;
            $display("FAIL simult: got ep %0b eo %0b pkt %0d want 1 1 1",
                     err_persist, err_order, pkt_count);
        end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        oracle = 1'b1;
        i_irdy = 1'b1;
        for (int i = 0; i < 257; i++) begin
            i_data = 8'(i);
            step();
        end
        checks++;
        if (err_order !== 1'b0) begin
            errors++;
            $display("FAIL seq_wrap: got %0b want 0", err_order);
        end
        i_data = 8'h05;
        step();
        checks++;
        if (err_order !== 1'b1) begin
            errors++;
            $display("FAIL seq_gap: got %0b want 1", err_order);
        end
        i_data = 8'h06;
        step();
        i_irdy = 1'b0;
        checks++;
        if (err_order !== 1'b1 || pkt_count !== 16'd259 || err_persist !== 1'b0) begin
            errors++;
            $display("FAIL seq_resync: got eo %0b pkt %0d ep %0b want 1 259 0",
                     err_order, pkt_count, err_persist);
        end
    endtask

    task automatic test_reset_mid_block();
        do_reset();
        i_irdy = 1'b1;
        i_data = 8'h03;
        step();
        step();
        checks++;
        if (stall_cnt !== 8'd2) begin
            errors++;
            $display("FAIL midblk_stall: got %0d want 2", stall_cnt);
        end
        reset  = 1'b1;
        oracle = 1'b1;
        #1;
        checks++;
        if (i_trdy !== 1'b0) begin
            errors++;
            $display("FAIL midblk_trdy: got %0b want 0", i_trdy);
        end
        step();
        checks++;
        if (stall_cnt !== 8'd0 || pkt_count !== 16'd0 || err_persist !== 1'b0
            || err_order !== 1'b0 || i_trdy !== 1'b0) begin
            errors++;
            $display("FAIL midblk_reset: got stall %0d pkt %0d ep %0b eo %0b trdy %0b",
                     stall_cnt, pkt_count, err_persist, err_order, i_trdy);
        end
        reset  = 1'b0;
        i_data = 8'h00;
        step();
        i_irdy = 1'b0;
        checks++;
        if (pkt_count !== 16'd1 || err_order !== 1'b0 || err_persist !== 1'b0) begin
            errors++;
            $display("FAIL midblk_after: got pkt %0d eo %0b ep %0b want 1 0 0",
                     pkt_count, err_order, err_persist);
        end
    endtask

    task automatic test_saturation();
        int xfers = 0;
        int mstall = 0;
        logic mtrdy;
        do_reset();
        i_irdy = 1'b1;
        i_data = 8'h00;
        for (int cyc = 0; cyc < 200 && xfers < 20; cyc++) begin
            oracle = 1'($urandom_range(0, 1));
            mtrdy  = oracle || (mstall == 4);
            #1;
            checks++;
            if (i_trdy !== mtrdy || i_trdy4 !== mtrdy) begin
                errors++;
                $display("FAIL sat_trdy: got %0b/%0b want %0b (cycle %0d)",
                         i_trdy, i_trdy4, mtrdy, cyc);
            end
            step();
            if (mtrdy) begin
                xfers++;
                i_data = i_data + 8'd1;
                mstall = 0;
            end else begin
                mstall = (mstall == 4) ? 4 : mstall + 1;
            end
        end
        i_irdy = 1'b0;
        checks++;
        if (xfers != 20) begin
            errors++;
            $display("FAIL sat_budget: got %0d transfers want 20", xfers);
        end
        checks++;
        if (pkt_count4 !== 4'd15 || pkt_count !== 16'd20) begin
            errors++;
            $display("FAIL sat_count: got %0d/%0d want 15/20", pkt_count4, pkt_count);
        end
        checks++;
        if (err_order4 !== 1'b0 || err_persist4 !== 1'b0) begin
            errors++;
            $display("FAIL sat_err: got %0b%0b want 00", err_persist4, err_order4);
        end
    endtask

    initial begin
        test_reset();
        test_oracle_accept();
        test_forced();
        test_persist();
        test_simultaneous();
        test_seq_wrap();
        test_reset_mid_block();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
